// File: rtl/mpa_add_ctrl.sv
// mpa_add_ctrl: multi-word adder that reuses one 32-bit add stage across WORDS
// words, least-significant word first, with a fixed latency of WORDS cycles.
// Optional subtraction (a + ~b with carry-in 1) is enabled by macro MPA_SUB_EN.
module mpa_add_ctrl #(
  parameter int unsigned WORDS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [32*WORDS-1:0] a,
  input  logic [32*WORDS-1:0] b,
  input  logic                ci,
`ifdef MPA_SUB_EN
  input  logic                sub,
`endif
  output logic [32*WORDS-1:0] s,
  output logic                co,
  output logic                busy,
  output logic                done
);

  localparam int unsigned CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic                    accept;
  logic                    last;
  logic [CW-1:0]           cnt;
  logic                    carry_r;
  logic                    sub_r;
  logic                    sub_in;
  logic [WORDS-1:0][31:0]  a_w;
  logic [WORDS-1:0][31:0]  b_w;
  logic [WORDS-1:0][31:0]  part;
  logic [WORDS-1:0][31:0]  part_nx;
  logic [31:0]             b_sel;
  logic [31:0]             sum_c;
  logic                    cout_c;

  assign a_w = a;
  assign b_w = b;

`ifdef MPA_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(WORDS - 1)) begin
          last     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Shared 32-bit add stage on the current word; partial result with it merged in
  always_comb begin
    b_sel           = sub_r ? ~b_w[cnt] : b_w[cnt];
    {cout_c, sum_c} = 33'(a_w[cnt]) + 33'(b_sel) + 33'(carry_r);
    part_nx         = part;
    part_nx[cnt]    = sum_c;
  end

  // Datapath: word counter, carry chain, partial result and visible outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      carry_r <= 1'b0;
      sub_r   <= 1'b0;
      part    <= '0;
      s       <= '0;
      co      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        cnt     <= '0;
        sub_r   <= sub_in;
        carry_r <= sub_in ? 1'b1 : ci;
        busy    <= 1'b1;
      end else if (state == RUN) begin
        part    <= part_nx;
        carry_r <= cout_c;
        cnt     <= cnt + CW'(1);
        if (last) begin
          s    <= part_nx;
          co   <= cout_c;
          cnt  <= '0;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mpa_add_ctrl.sv
// tb_mpa_add_ctrl: directed self-checking bench for mpa_add_ctrl (WORDS=4).
// Subtraction vectors are exercised when MPA_SUB_EN is defined.
module tb_mpa_add_ctrl;

  localparam int unsigned W = 128;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
`ifdef MPA_SUB_EN
  logic         sub;
`endif
  logic [W-1:0] s;
  logic         co;
  logic         busy;
  logic         done;

  int checks;
  int errors;

  mpa_add_ctrl #(.WORDS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .ci      (ci),
`ifdef MPA_SUB_EN
    .sub     (sub),
`endif
    .s       (s),
    .co      (co),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Run one operation; returns at the done cycle (+1 after the edge).
  // lat = cycles from accepting edge to done (0 on timeout), nbusy = busy cycles,
  // chg = 1 if s/co moved before done.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic civ, input logic subv,
                       output logic [W-1:0] so, output logic coo,
                       output int lat, output int nbusy, output logic chg);
    logic [W-1:0] s0;
    logic         c0;
    a = av; b = bv; ci = civ;
`ifdef MPA_SUB_EN
    sub = subv;
`else
    if (subv) $display("note: sub requested but MPA_SUB_EN undefined");
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s0 = s; c0 = co;
    lat = 0; nbusy = 0; chg = 1'b0;
    if (busy) nbusy++;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) nbusy++;
      if (s !== s0 || co !== c0) chg = 1'b1;
    end
    so = s; coo = co;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; a = '0; b = '0; ci = 1'b0;
`ifdef MPA_SUB_EN
    sub = 1'b0;
`endif
    #3;
    checks++;
    if (s !== '0 || co !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: s=%h co=%b busy=%b done=%b, want all 0", s, co, busy, done);
    end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_zero();
    logic [W-1:0] so; logic coo; int lat; int nb; logic chg;
    do_op('0, '0, 1'b0, 1'b0, so, coo, lat, nb, chg);
    checks++;
    if (so !== '0 || coo !== 1'b0) begin
      errors++;
      $display("FAIL zero_sum: s=%h co=%b, want 0 0", so, coo);
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL zero_latency: got %0d, want 4", lat);
    end
    checks++;
    if (nb != 4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_busy: busy cycles %0d busy_at_done=%b, want 4 and 0", nb, busy);
    end
  endtask

  task automatic test_ripple();
    logic [W-1:0] so; logic coo; int lat; int nb; logic chg;
    do_op({W{1'b1}}, '0, 1'b1, 1'b0, so, coo, lat, nb, chg);
    checks++;
    if (so !== '0 || coo !== 1'b1 || lat != 4) begin
      errors++;
      $display("FAIL ripple_carry: s=%h co=%b lat=%0d, want 0 1 4", so, coo, lat);
    end
  endtask

  task automatic test_patterns();
    logic [W-1:0] so; logic coo; int lat; int nb; logic chg;
    do_op({4{32'h0000_FFFF}}, {4{32'hFFFF_0000}}, 1'b0, 1'b0, so, coo, lat, nb, chg);
    checks++;
    if (so !== {W{1'b1}} || coo !== 1'b0) begin
      errors++;
      $display("FAIL halves_sum: s=%h co=%b, want all ones 0", so, coo);
    end
    checks++;
    if (chg !== 1'b0) begin
      errors++;
      $display("FAIL hold_during_run: s/co changed=%b, want 0", chg);
    end
    do_op({96'h0, 32'h135F_A562}, {96'h0, 32'h3561_4642}, 1'b0, 1'b0, so, coo, lat, nb, chg);
    checks++;
    if (so !== {96'h0, 32'h48C0_EBA4} || coo !== 1'b0 || lat != 4) begin
      errors++;
      $display("FAIL word0_sum: s=%h co=%b lat=%0d, want 48c0eba4 0 4", so, coo, lat);
    end
    // Held outputs between operations
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (s !== {96'h0, 32'h48C0_EBA4} || co !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: s=%h co=%b done=%b, want 48c0eba4 0 0", s, co, done);
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] exp_s;
    int ndone;
    logic [W-1:0] s_at_done;
    exp_s = 128'h0000_0001_FFFF_FFFF_0000_0001_0000_0000;
    a = 128'h0000_0001_FFFF_FFFF_0000_0000_FFFF_FFFF;
    b = 128'h1; ci = 1'b0;
`ifdef MPA_SUB_EN
    sub = 1'b0;
`endif
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    ndone = 0; s_at_done = '0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        ndone++;
        s_at_done = s;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL ignore_done_count: got %0d, want 1", ndone);
    end
    checks++;
    if (s_at_done !== exp_s || co !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result: s=%h co=%b, want %h 0", s_at_done, co, exp_s);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] so; logic coo; int lat; int nb; logic chg;
    do_op(128'h5, 128'h6, 1'b1, 1'b0, so, coo, lat, nb, chg);
    checks++;
    if (so !== 128'hC || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: s=%h done=%b, want c 1", so, done);
    end
    // start is raised during the done cycle
    do_op({4{32'h8000_0000}}, {4{32'h8000_0000}}, 1'b0, 1'b0, so, coo, lat, nb, chg);
    checks++;
    if (so !== {32'h1, 32'h1, 32'h1, 32'h0} || coo !== 1'b1 || lat != 4 || nb != 4) begin
      errors++;
      $display("FAIL b2b_second: s=%h co=%b lat=%0d busy=%0d, want 1_1_1_0 1 4 4", so, coo, lat, nb);
    end
  endtask

  task automatic test_reset_abort();
    int ndone;
    a = {W{1'b1}}; b = 128'h3; ci = 1'b0;
`ifdef MPA_SUB_EN
    sub = 1'b0;
`endif
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (s !== '0 || co !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: s=%h co=%b busy=%b done=%b, want all 0", s, co, busy, done);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++;
    if (ndone != 0 || s !== '0 || co !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_after: dones=%0d s=%h co=%b busy=%b, want 0 0 0 0", ndone, s, co, busy);
    end
    // First start after release is accepted at the first edge
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL first_start: busy=%b, want 1", busy);
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

`ifdef MPA_SUB_EN
  task automatic test_sub();
    logic [W-1:0] so; logic coo; int lat; int nb; logic chg;
    do_op(128'h5, 128'h7, 1'b0, 1'b1, so, coo, lat, nb, chg);
    checks++;
    if (so !== {{124{1'b1}}, 4'hE} || coo !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: s=%h co=%b, want ff..fe 0", so, coo);
    end
    do_op(128'h7, 128'h5, 1'b0, 1'b1, so, coo, lat, nb, chg);
    checks++;
    if (so !== 128'h2 || coo !== 1'b1) begin
      errors++;
      $display("FAIL sub_noborrow: s=%h co=%b, want 2 1", so, coo);
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_zero();
    test_ripple();
    test_patterns();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
`ifdef MPA_SUB_EN
    test_sub();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
